// File: rtl/instr_fetch_seq.sv
// Instruction fetch and sequencing stage: owns the PC, fetches words into an
// instruction register and issues decoded fields to the datapath.
module instr_fetch_seq #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [7:0]       opcode,
  output logic [3:0]       rd,
  output logic [3:0]       rs,
  output logic [15:0]      imm,
  output logic             issue_valid,
  input  logic             issue_ready,
  input  logic             jump,
  input  logic             halt,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_ISSUE  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic        fetching;

  // The request is gated by rst so no fetch is presented during reset.
  assign imem_req  = fetching & ~rst;
  assign imem_addr = pc;
  assign opcode    = ir[31:24];
  assign rd        = ir[23:20];
  assign rs        = ir[19:16];
  assign imm       = ir[15:0];

  // Single sequencing FSM; halt wins over jump, jump over sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= '0;
      ir          <= '0;
      fetching    <= 1'b1;
      issue_valid <= 1'b0;
      halted      <= 1'b0;
      retired     <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir          <= imem_rdata;
            fetching    <= 1'b0;
            issue_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            if (retired != {CNT_W{1'b1}}) begin
              retired <= retired + CNT_W'(1);
            end
            if (halt) begin
              halted <= 1'b1;
              state  <= S_HALTED;
            end else begin
              if (jump) begin
                pc <= imm[PC_W-1:0];
              end else begin
                pc <= pc + PC_W'(1);
              end
              fetching <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ready = 1'b0;
  logic        issue_ready = 1'b0;
  logic        jump = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] imem_rdata;

  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [7:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [15:0] imm;
  logic        issue_valid;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] retired;

  logic        s_req;
  logic [7:0]  s_addr;
  logic [7:0]  s_opcode;
  logic [3:0]  s_rd;
  logic [3:0]  s_rs;
  logic [15:0] s_imm;
  logic        s_valid;
  logic [7:0]  s_pc;
  logic        s_halted;
  logic [2:0]  s_retired;

  logic [31:0] mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  instr_fetch_seq #(.PC_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .opcode(opcode),
    .rd(rd), .rs(rs), .imm(imm), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .jump(jump), .halt(halt), .pc(pc),
    .halted(halted), .retired(retired)
  );

  // Narrow counter copy so retired saturation is reachable in a short run.
  instr_fetch_seq #(.PC_W(8), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .imem_req(s_req), .imem_addr(s_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .opcode(s_opcode),
    .rd(s_rd), .rs(s_rs), .imm(s_imm), .issue_valid(s_valid),
    .issue_ready(issue_ready), .jump(jump), .halt(halt), .pc(s_pc),
    .halted(s_halted), .retired(s_retired)
  );

  typedef struct {
    logic       rst, rdy, irdy, jmp, hlt;
    logic       req;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] op;
    logic [7:0] pcv;
    logic       hlt_o;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs [12];

  // reference model state
  int          m_pc;
  int          m_ret;
  bit          m_halted;
  bit          m_rst;
  logic [31:0] m_ir;
  logic [31:0] pending [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic irdy,
                               input logic j, input logic h);
    rst         = r;
    imem_ready  = rdy;
    issue_ready = irdy;
    jump        = j;
    halt        = h;
  endtask

  task automatic resetDut();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic modelStep(input bit r, input bit rdy, input bit irdy, input bit j, input bit h);
    logic [31:0] w;
    m_rst = r;
    if (r) begin
      m_pc = 0; m_ret = 0; m_halted = 0; m_ir = '0;
      pending.delete();
    end else if (m_halted) begin
      m_halted = 1;
    end else if (pending.size() == 0) begin
      if (rdy) begin
        m_ir = mem[m_pc];
        pending.push_back(m_ir);
      end
    end else if (irdy) begin
      w = pending.pop_front();
      m_ret++;
      if (h) m_halted = 1;
      else if (j) m_pc = int'(w[7:0]);
      else m_pc = (m_pc + 1) % 256;
    end
  endtask

  initial begin
    int valid_cycles;

    vecs[0]  = '{0,1,1,0,0, 1,8'h00,0,8'h00,8'h00,0,16'd0};
    vecs[1]  = '{0,1,1,0,0, 0,8'h00,1,8'h09,8'h00,0,16'd0};
    vecs[2]  = '{0,1,1,0,0, 1,8'h01,0,8'h09,8'h01,0,16'd1};
    vecs[3]  = '{0,1,1,0,0, 0,8'h01,1,8'h0A,8'h01,0,16'd1};
    vecs[4]  = '{0,1,1,0,0, 1,8'h02,0,8'h0A,8'h02,0,16'd2};
    vecs[5]  = '{0,1,1,0,1, 0,8'h02,1,8'hFF,8'h02,0,16'd2};
    vecs[6]  = '{0,1,1,1,0, 0,8'h02,0,8'hFF,8'h02,1,16'd3};
    vecs[7]  = '{0,0,1,1,1, 0,8'h02,0,8'hFF,8'h02,1,16'd3};
    vecs[8]  = '{1,1,1,0,0, 0,8'h02,0,8'hFF,8'h02,1,16'd3};
    vecs[9]  = '{0,1,0,0,0, 1,8'h00,0,8'h00,8'h00,0,16'd0};
    vecs[10] = '{0,0,1,0,0, 0,8'h00,1,8'h09,8'h00,0,16'd0};
    vecs[11] = '{0,0,0,0,0, 1,8'h01,0,8'h09,8'h01,0,16'd1};

    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    mem[0] = 32'h09120000;
    mem[1] = 32'h0A340000;
    mem[2] = 32'hFF000000;

    // sequential run, halt, reset and restart
    resetDut();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].irdy, vecs[i].jmp, vecs[i].hlt);
      #1;
      checkOutput($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      checkOutput($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
      checkOutput($sformatf("vec%0d_valid", i), 32'(issue_valid), 32'(vecs[i].valid));
      checkOutput($sformatf("vec%0d_opcode", i), 32'(opcode), 32'(vecs[i].op));
      checkOutput($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].pcv));
      checkOutput($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].hlt_o));
      checkOutput($sformatf("vec%0d_retired", i), 32'(retired), 32'(vecs[i].ret));
      @(negedge clk);
    end

    // jump
    mem[0] = 32'h05000010;
    mem[16] = 32'h01000000;
    resetDut();
    applyStimulus(0, 1, 1, 0, 0);
    #1 checkOutput("jump_fetch_addr", 32'(imem_addr), 32'h0);
    @(negedge clk);
    applyStimulus(0, 1, 1, 1, 0);
    #1;
    checkOutput("jump_valid", 32'(issue_valid), 32'h1);
    checkOutput("jump_imm", 32'(imm), 32'h0010);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("jump_target_addr", 32'(imem_addr), 32'h10);
    checkOutput("jump_req", 32'(imem_req), 32'h1);
    checkOutput("jump_retired", 32'(retired), 32'h1);

    // back-pressure on both handshakes
    mem[0] = 32'h07AB1234;
    resetDut();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, k[0], ~k[0]);
      #1;
      checkOutput("bp_wait_addr", 32'(imem_addr), 32'h0);
      checkOutput("bp_wait_req", 32'(imem_req), 32'h1);
      @(negedge clk);
    end
    applyStimulus(0, 1, 0, 0, 0);
    #1 checkOutput("bp_accept_addr", 32'(imem_addr), 32'h0);
    @(negedge clk);
    valid_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 0, k[0], ~k[0]);
      #1;
      if (issue_valid) valid_cycles++;
      checkOutput("bp_stall_opcode", 32'(opcode), 32'h07);
      checkOutput("bp_stall_req", 32'(imem_req), 32'h0);
      @(negedge clk);
    end
    applyStimulus(0, 0, 1, 0, 0);
    #1;
    if (issue_valid) valid_cycles++;
    checkOutput("bp_hs_opcode", 32'(opcode), 32'h07);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    if (issue_valid) valid_cycles++;
    checkOutput("bp_valid_cycles", 32'(valid_cycles), 32'd5);
    checkOutput("bp_retired", 32'(retired), 32'h1);
    checkOutput("bp_pc", 32'(pc), 32'h1);
    checkOutput("bp_halted", 32'(halted), 32'h0);
    checkOutput("bp_next_req", 32'(imem_req), 32'h1);

    // PC wrap from 0xFF
    mem[0] = 32'h050000FF;
    mem[255] = 32'h01000000;
    resetDut();
    applyStimulus(0, 1, 1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 1, 1, 1, 0);
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 0);
    #1 checkOutput("wrap_addr_ff", 32'(imem_addr), 32'hFF);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("wrap_addr_00", 32'(imem_addr), 32'h00);
    checkOutput("wrap_req", 32'(imem_req), 32'h1);
    checkOutput("wrap_retired", 32'(retired), 32'h2);

    // halt beats jump, then stays halted
    mem[0] = 32'h30000033;
    resetDut();
    applyStimulus(0, 1, 1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 1, 1, 1, 1);
    #1 checkOutput("hp_valid", 32'(issue_valid), 32'h1);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, k[0], ~k[0], k[1], 0);
      #1;
      checkOutput("hp_halted", 32'(halted), 32'h1);
      checkOutput("hp_pc", 32'(pc), 32'h0);
      checkOutput("hp_req", 32'(imem_req), 32'h0);
      checkOutput("hp_valid_low", 32'(issue_valid), 32'h0);
      checkOutput("hp_retired", 32'(retired), 32'h1);
      @(negedge clk);
    end

    // reset during ISSUE at pc=5
    for (int a = 0; a < 6; a++) mem[a] = 32'h01000000;
    resetDut();
    applyStimulus(0, 1, 1, 0, 0);
    repeat (11) @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0);
    #1;
    checkOutput("rm_pc_before", 32'(pc), 32'h5);
    checkOutput("rm_valid_before", 32'(issue_valid), 32'h1);
    checkOutput("rm_req_gated", 32'(imem_req), 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("rm_pc", 32'(pc), 32'h0);
    checkOutput("rm_valid", 32'(issue_valid), 32'h0);
    checkOutput("rm_retired", 32'(retired), 32'h0);
    checkOutput("rm_req", 32'(imem_req), 32'h1);
    checkOutput("rm_addr", 32'(imem_addr), 32'h0);

    // randomized run against the reference model
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    resetDut();
    m_pc = 0; m_ret = 0; m_halted = 0; m_rst = 0; m_ir = '0;
    pending.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r, rdy, irdy, j, h;
      #1;
      checkOutput("rnd_req", 32'(imem_req), 32'(!m_rst && !m_halted && pending.size() == 0));
      checkOutput("rnd_valid", 32'(issue_valid), 32'(pending.size() != 0));
      checkOutput("rnd_pc", 32'(pc), 32'(m_pc));
      checkOutput("rnd_addr", 32'(imem_addr), 32'(m_pc));
      checkOutput("rnd_opcode", 32'(opcode), 32'(m_ir[31:24]));
      checkOutput("rnd_rd_rs", 32'({rd, rs}), 32'(m_ir[23:16]));
      checkOutput("rnd_imm", 32'(imm), 32'(m_ir[15:0]));
      checkOutput("rnd_halted", 32'(halted), 32'(m_halted));
      checkOutput("rnd_retired", 32'(retired), 32'((m_ret > 65535) ? 65535 : m_ret));
      checkOutput("rnd_retired_sat", 32'(s_retired), 32'((m_ret > 7) ? 7 : m_ret));
      r    = ($urandom_range(99) < 2);
      rdy  = ($urandom_range(99) < 60);
      irdy = ($urandom_range(99) < 60);
      j    = ($urandom_range(99) < 30);
      h    = ($urandom_range(99) < 4);
      applyStimulus(r, rdy, irdy, j, h);
      modelStep(r, rdy, irdy, j, h);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
